booth_divider: RTL and testbench



---
 rtl/booth_divider.sv | 131 +++++++++++++
 tb/tb_booth_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// Sequential signed divider for the HI/LO unit.
// Runs a radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, then applies the sign correction. The result is packed as
// Z = {remainder, quotient}, the same split the multiplier uses.
module booth_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic [2*WIDTH-1:0] Z,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, quo_reg, absy_reg, x_reg;
  logic [CW-1:0]      cnt_reg;
  logic               sign_x_reg, sign_q_reg, dbz_reg;
  logic [2*WIDTH-1:0] z_reg;
  logic               done_reg, div_by_zero_reg;

  logic [WIDTH-1:0]   absx, absy;
  logic [WIDTH:0]     rem_shift, trial;
  logic               trial_ok;
  logic [WIDTH-1:0]   rem_step, quo_step, q_fix, r_fix;

  // Magnitudes of the incoming operands; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned number.
  always_comb begin
    absx = X[WIDTH-1] ? -X : X;
    absy = Y[WIDTH-1] ? -Y : Y;
  end

  // One restoring step: shift {rem, quo} left, try to subtract the divisor,
  // keep the difference only when it did not go negative.
  // rem < |Y| <= 2^(WIDTH-1), so the shifted remainder never exceeds WIDTH bits
  // and bit WIDTH of the trial is a reliable sign bit.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, absy_reg};
    trial_ok  = ~trial[WIDTH];
    rem_step  = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_step  = {quo_reg[WIDTH-2:0], trial_ok};
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    q_fix = sign_q_reg ? -quo_reg : quo_reg;
    r_fix = sign_x_reg ? -rem_reg : rem_reg;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a zero divisor skips the iteration entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (Y == '0) ? FIX : CALC;
      CALC:    if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, publish in FIX.
  always_ff @(posedge clock) begin
    if (clear) begin
      rem_reg         <= '0;
      quo_reg         <= '0;
      absy_reg        <= '0;
      x_reg           <= '0;
      cnt_reg         <= '0;
      sign_x_reg      <= 1'b0;
      sign_q_reg      <= 1'b0;
      dbz_reg         <= 1'b0;
      z_reg           <= '0;
      done_reg        <= 1'b0;
      div_by_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg           <= X;
            quo_reg         <= absx;
            absy_reg        <= absy;
            rem_reg         <= '0;
            cnt_reg         <= '0;
            sign_x_reg      <= X[WIDTH-1];
            sign_q_reg      <= X[WIDTH-1] ^ Y[WIDTH-1];
            dbz_reg         <= (Y == '0);
            div_by_zero_reg <= 1'b0;
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          done_reg <= 1'b1;
          if (dbz_reg) begin
            z_reg           <= {x_reg, {WIDTH{1'b1}}};
            div_by_zero_reg <= 1'b1;
          end else begin
            z_reg <= {r_fix, q_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign Z           = z_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_booth_divider.sv
// Directed and randomized checks of booth_divider against a plain-arithmetic
// reference: truncating signed division, remainder with the dividend's sign.
module tb_booth_divider;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic [63:0] Z;
  logic        busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;

  booth_divider #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .X(X), .Y(Y),
    .Z(Z), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference result computed with 64-bit signed arithmetic.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    longint xl, yl, q, r;
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    xl = longint'($signed(x));
    yl = longint'($signed(y));
    q  = xl / yl;
    r  = xl % yl;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request, let the next rising edge accept it,
  // and return at the following negedge with start released.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; X = x; Y = y;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    X = $urandom; Y = $urandom;
  endtask

  // Step negedges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y, input string tag);
    int n;
    logic [63:0] exp;
    exp = model(x, y);
    launch(x, y);
    chk({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    chk({tag, "_dbz_cleared_on_accept"}, 64'(div_by_zero), 64'd0);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), (y == 32'd0) ? 64'd1 : 64'd33);
    chk({tag, "_z"}, Z, exp);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(y == 32'd0));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    $display("[TB] %s X=%h Y=%h Z=%h latency=%0d", tag, x, y, Z, n);
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_z_held"}, Z, exp);
  endtask

  initial begin
    int n, extra, seen_done;
    logic [31:0] rx, ry;

    // Reset
    repeat (2) @(negedge clock);
    clear = 1'b0;
    chk("reset_z", Z, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);

    // Directed vectors, grounded against literal expectations too
    run(32'd100, 32'd7, "pos_pos");
    chk("pos_pos_literal", Z, 64'h00000002_0000000E);
    run(-32'sd100, 32'd7, "neg_pos");
    chk("neg_pos_literal", Z, 64'hFFFFFFFE_FFFFFFF2);
    run(32'd100, -32'sd7, "pos_neg");
    chk("pos_neg_literal", Z, 64'h00000002_FFFFFFF2);
    run(32'h80000000, 32'hFFFFFFFF, "overflow");
    chk("overflow_literal", Z, 64'h00000000_80000000);
    run(32'd5, 32'd9, "small_dividend");
    chk("small_dividend_literal", Z, 64'h00000005_00000000);

    // Divide by zero, then a normal start clears the flag
    run(32'd1234, 32'd0, "div_zero");
    chk("div_zero_literal", Z, 64'h000004D2_FFFFFFFF);
    run(32'd10, 32'd3, "after_dbz");

    // start while busy is ignored; reassert in the done cycle is accepted
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    start = 1'b1; X = 32'd50; Y = 32'd5;
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
    chk("ignore_latency", 64'(n + 10), 64'd33);
    chk("ignore_z", Z, model(32'd100, 32'd7));
    $display("[TB] busy_ignore X=%h Y=%h Z=%h", 32'd100, 32'd7, Z);
    launch(32'd50, 32'd5);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(n);
    chk("b2b_latency", 64'(n), 64'd33);
    chk("b2b_z", Z, 64'h00000000_0000000A);
    $display("[TB] back_to_back X=%h Y=%h Z=%h", 32'd50, 32'd5, Z);
    @(negedge clock);

    // clear aborts an operation in flight
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_z", Z, 64'd0);
    chk("clear_done", 64'(done), 64'd0);
    seen_done = 0;
    for (extra = 0; extra < 40; extra++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done++;
    end
    chk("clear_no_done", 64'(seen_done), 64'd0);
    $display("[TB] clear_abort busy=%b Z=%h", busy, Z);
    run(32'd9, 32'd2, "after_clear");
    chk("after_clear_literal", Z, 64'h00000001_00000004);

    // Randomized operands with mixed magnitudes and signs
    for (int i = 0; i < 24; i++) begin
      rx = $urandom;
      case (i % 4)
        0: ry = $urandom;
        1: ry = $urandom_range(1, 20);
        2: ry = -$urandom_range(1, 1000);
        default: ry = (i == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      if (i % 5 == 0) rx = rx >> $urandom_range(0, 31);
      run(rx, ry, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
